// File: rtl/dmem_arb_pkg.sv
// Shared constants and types for the data-memory arbiter.
package dmem_arb_pkg;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_LDR = 1'b1;

    localparam int DEF_BASE_ADDR  = 512;
    localparam int DEF_DATA_WORDS = 512;
    localparam int DEF_MEM_AW     = 10;

    typedef logic arb_port_t;

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational winner selection for the two data-memory requesters.
// DMEM_ARB_RR_EN selects round-robin tie-break; otherwise port 0 wins ties.
module dmem_arb_pick
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       lock_active_i,
    input  arb_port_t  last_owner_i,
    output logic       win_vld_o,
    output arb_port_t  win_o
);

    // A lock always belongs to the most recent grantee, so last_owner doubles as lock owner.
    always_comb begin
        win_vld_o = 1'b0;
        win_o     = PORT_CPU;
        if (lock_active_i && req_i[last_owner_i]) begin
            win_vld_o = 1'b1;
            win_o     = last_owner_i;
        end else if (&req_i) begin
            win_vld_o = 1'b1;
`ifdef DMEM_ARB_RR_EN
            win_o     = ~last_owner_i;
`else
            win_o     = PORT_CPU;
`endif
        end else if (req_i[0]) begin
            win_vld_o = 1'b1;
            win_o     = PORT_CPU;
        end else if (req_i[1]) begin
            win_vld_o = 1'b1;
            win_o     = PORT_LDR;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the data blockRAM: grants, base offset, range check, read return.
// Tie-break policy set by DMEM_ARB_RR_EN (defined: round-robin, undefined: port 0 priority).
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int BASE_ADDR  = DEF_BASE_ADDR,
    parameter int DATA_WORDS = DEF_DATA_WORDS,
    parameter int MEM_AW     = DEF_MEM_AW
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic [15:0]       addr0,
    input  logic [15:0]       addr1,
    input  logic [15:0]       wdata0,
    input  logic [15:0]       wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [15:0]       rdata0,
    output logic [15:0]       rdata1,
    output logic              err0,
    output logic              err1,
    output logic              mem_en,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [15:0]       mem_di,
    input  logic [15:0]       mem_dout
);

    arb_port_t last_owner_q, last_owner_d;
    logic      lock_active_q, lock_active_d;
    logic      pend_valid_q, pend_valid_d;
    arb_port_t pend_port_q, pend_port_d;
    logic      pend_err_q, pend_err_d;
    logic      pend_we_q, pend_we_d;

    logic      win_vld;
    arb_port_t win;
    logic      grant;
    logic [15:0] sel_addr;
    logic [15:0] sel_wdata;
    logic        sel_we;
    logic        sel_lock;
    logic        in_range;

    dmem_arb_pick u_pick (
        .req_i        ({req1, req0}),
        .lock_active_i(lock_active_q),
        .last_owner_i (last_owner_q),
        .win_vld_o    (win_vld),
        .win_o        (win)
    );

    always_comb begin
        grant     = win_vld && !reset;
        sel_addr  = (win == PORT_LDR) ? addr1  : addr0;
        sel_wdata = (win == PORT_LDR) ? wdata1 : wdata0;
        sel_we    = (win == PORT_LDR) ? we1    : we0;
        sel_lock  = (win == PORT_LDR) ? lock1  : lock0;
        in_range  = ({16'b0, sel_addr} < 32'(DATA_WORDS));

        gnt0     = grant && (win == PORT_CPU);
        gnt1     = grant && (win == PORT_LDR);
        mem_en   = 1'b0;
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_di   = '0;
        // Out-of-range accesses never reach the RAM, so they cannot wrap into the instruction region.
        if (grant && in_range) begin
            mem_en   = 1'b1;
            mem_we   = sel_we;
            mem_addr = sel_addr[MEM_AW-1:0] + MEM_AW'(BASE_ADDR);
            mem_di   = sel_wdata;
        end

        last_owner_d  = grant ? win : last_owner_q;
        lock_active_d = grant && sel_lock;
        pend_valid_d  = grant;
        pend_port_d   = win;
        pend_err_d    = !in_range;
        pend_we_d     = sel_we;
    end

    always_comb begin
        rvalid0 = pend_valid_q && !pend_we_q && (pend_port_q == PORT_CPU);
        rvalid1 = pend_valid_q && !pend_we_q && (pend_port_q == PORT_LDR);
        err0    = pend_valid_q && pend_err_q && (pend_port_q == PORT_CPU);
        err1    = pend_valid_q && pend_err_q && (pend_port_q == PORT_LDR);
        rdata0  = (rvalid0 && !pend_err_q) ? mem_dout : 16'h0000;
        rdata1  = (rvalid1 && !pend_err_q) ? mem_dout : 16'h0000;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_owner_q  <= PORT_LDR;
            lock_active_q <= 1'b0;
            pend_valid_q  <= 1'b0;
            pend_port_q   <= PORT_CPU;
            pend_err_q    <= 1'b0;
            pend_we_q     <= 1'b0;
        end else begin
            last_owner_q  <= last_owner_d;
            lock_active_q <= lock_active_d;
            pend_valid_q  <= pend_valid_d;
            pend_port_q   <= pend_port_d;
            pend_err_q    <= pend_err_d;
            pend_we_q     <= pend_we_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a write-first RAM model behind it.
module tb_dmem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        req0, req1, we0, we1, lock0, lock1;
    logic [15:0] addr0, addr1, wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1;
    logic [15:0] rdata0, rdata1;
    logic        mem_en, mem_we;
    logic [9:0]  mem_addr;
    logic [15:0] mem_di, mem_dout;

    logic [15:0] ram [0:1023];
    logic [15:0] shadow [0:1023];
    logic        ram_loaded = 1'b0;

    typedef struct {
        logic        rv0, rv1, er0, er1;
        logic [15:0] rd0, rd1;
    } resp_t;
    resp_t exp_q[$];

    int n_chk = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    dmem_arbiter dut (
        .clock(clock), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .lock0(lock0), .lock1(lock1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_di(mem_di), .mem_dout(mem_dout)
    );

    always @(posedge clock) begin
        if (!ram_loaded) begin
            for (int i = 0; i < 1024; i++) ram[i] <= 16'h0000;
            ram[517]   <= 16'hBEEF;
            ram[88]    <= 16'h5A5A;
            ram_loaded <= 1'b1;
        end else if (mem_en) begin
            if (mem_we) begin
                ram[mem_addr] <= mem_di;
                mem_dout      <= mem_di;
            end else begin
                mem_dout <= ram[mem_addr];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        req0 = 0; we0 = 0; lock0 = 0; addr0 = 0; wdata0 = 0;
        req1 = 0; we1 = 0; lock1 = 0; addr1 = 0; wdata1 = 0;
    endtask

    task automatic set0(input logic w, input logic l, input logic [15:0] a, input logic [15:0] d);
        req0 = 1; we0 = w; lock0 = l; addr0 = a; wdata0 = d;
    endtask

    task automatic set1(input logic w, input logic l, input logic [15:0] a, input logic [15:0] d);
        req1 = 1; we1 = w; lock1 = l; addr1 = a; wdata1 = d;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"},  {gnt0, gnt1}, 0);
        chk({tag, "_rv"},   {rvalid0, rvalid1}, 0);
        chk({tag, "_err"},  {err0, err1}, 0);
        chk({tag, "_rd"},   {rdata0, rdata1}, 0);
        chk({tag, "_mem"},  {mem_en, mem_we}, 0);
        chk({tag, "_maddr"}, {22'b0, mem_addr}, 0);
        chk({tag, "_mdi"},  {16'b0, mem_di}, 0);
    endtask

    task automatic do_reset();
        reset = 1;
        req0 = 1; req1 = 1;
        #1;
        chk_all_zero("rst");
        idle();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 0;
        exp_q.delete();
        @(posedge clock);
        #1;
    endtask

    // One bus cycle: check grant/memory drive, queue the expected response, check it after the edge.
    task automatic step(input logic eg0, input logic eg1);
        resp_t       r;
        resp_t       o;
        logic [15:0] a, d;
        logic        w, inr;
        int          ma;
        r = '{default: 0};
        #1;
        chk("gnt0", gnt0, eg0);
        chk("gnt1", gnt1, eg1);
        if (eg0 || eg1) begin
            a   = eg1 ? addr1 : addr0;
            w   = eg1 ? we1 : we0;
            d   = eg1 ? wdata1 : wdata0;
            inr = (a < 16'd512);
            ma  = (int'(a) + 512) % 1024;
            chk("mem_en", mem_en, inr);
            if (inr) begin
                chk("mem_addr", mem_addr, ma);
                chk("mem_we", mem_we, w);
                if (w) begin
                    chk("mem_di", mem_di, d);
                    shadow[ma] = d;
                end
            end
            if (!w) begin
                if (eg1) begin r.rv1 = 1; r.rd1 = inr ? shadow[ma] : 16'h0; end
                else     begin r.rv0 = 1; r.rd0 = inr ? shadow[ma] : 16'h0; end
            end
            if (!inr) begin
                if (eg1) r.er1 = 1; else r.er0 = 1;
            end
        end else begin
            chk("mem_en_idle", mem_en, 0);
        end
        exp_q.push_back(r);
        @(posedge clock);
        #1;
        o = exp_q.pop_front();
        chk("rvalid0", rvalid0, o.rv0);
        chk("rvalid1", rvalid1, o.rv1);
        chk("err0", err0, o.er0);
        chk("err1", err1, o.er1);
        chk("rdata0", rdata0, o.rd0);
        chk("rdata1", rdata1, o.rd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) shadow[i] = 16'h0000;
        shadow[517] = 16'hBEEF;
        shadow[88]  = 16'h5A5A;
        reset = 1;
        idle();
        do_reset();

        // Basic read with base offset
        set0(0, 0, 16'd5, 0);
        step(1, 0);
        idle();
        step(0, 0);

        // Tie-break with both ports requesting from reset state
        do_reset();
        set0(0, 0, 16'd1, 0);
        set1(0, 0, 16'd2, 0);
`ifdef DMEM_ARB_RR_EN
        step(1, 0); step(0, 1); step(1, 0); step(0, 1);
`else
        step(1, 0); step(1, 0); step(1, 0); step(1, 0);
`endif
        idle();
        step(0, 0);

        // Locked burst on port 1, then release when it drops req
        set1(0, 1, 16'd7, 0);
        step(0, 1);
        set0(0, 0, 16'd8, 0);
        step(0, 1);
        step(0, 1);
        req1 = 0; lock1 = 0;
        step(1, 0);
        idle();
        step(0, 0);

        // Out-of-range write from port 1
        set1(1, 0, 16'd600, 16'h1234);
        step(0, 1);
        idle();
        chk("ram88_untouched", ram[88], 16'h5A5A);

        // Write then read back, port-1 routing, range boundaries
        set0(1, 0, 16'd3, 16'h00AA);
        step(1, 0);
        set0(0, 0, 16'd3, 0);
        step(1, 0);
        idle();
        set1(0, 0, 16'd5, 0);
        step(0, 1);
        idle();
        set0(0, 0, 16'd511, 0);
        step(1, 0);
        set0(0, 0, 16'd512, 0);
        step(1, 0);
        idle();
        set1(0, 0, 16'hFFFF, 0);
        step(0, 1);
        idle();
        step(0, 0);

        // Reset with a read in flight drops the response
        set0(0, 0, 16'd5, 0);
        #1;
        chk("gnt0_pre_rst", gnt0, 1);
        reset = 1;
        #1;
        chk_all_zero("midrst");
        idle();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 0;
        exp_q.delete();
        @(posedge clock);
        #1;
        chk("rvalid0_after_rst", rvalid0, 0);
        step(0, 0);
        set0(0, 0, 16'd3, 0);
        step(1, 0);
        idle();
        step(0, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

- Shares the single data `blockRAM` port between two requesters: port 0 (CPU `datapath`) and port 1 (program/data loader).
- Sits between the requesters and the data memory instance, and applies the data-region base offset.
- Grants at most one access per cycle and tracks the owner of each in-flight read, so read data returns to the correct port one cycle later.
- Supports locked bursts and flags out-of-range addresses.

## Interface
Parameters:
- `BASE_ADDR`, 512: word offset added to requester addresses to form the RAM address.
- `DATA_WORDS`, 512: number of valid data words; requester addresses at or above this value are out of range.
- `MEM_AW`, 10: RAM address width.

Ports:
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `req0`, `req1` in 1: access request from port 0 / port 1.
- `we0`, `we1` in 1: 1 = write, 0 = read.
- `lock0`, `lock1` in 1: hold the grant for the next cycle while the port keeps `req` asserted.
- `addr0`, `addr1` in 16: word address relative to the data region.
- `wdata0`, `wdata1` in 16: write data.
- `gnt0`, `gnt1` out 1: access accepted this cycle (combinational).
- `rvalid0`, `rvalid1` out 1: read data valid for that port.
- `rdata0`, `rdata1` out 16: read data; 0 when the matching `rvalid` is low.
- `err0`, `err1` out 1: pulses together with the response for an out-of-range access.
- `mem_en`, `mem_we` out 1: RAM enable and write enable.
- `mem_addr` out `MEM_AW`: RAM address.
- `mem_di` out 16: RAM write data.
- `mem_dout` in 16: RAM read data, valid one cycle after an enabled read.

## Operation
**Winner selection**
- Lock owner: if `lock_active` is set and that owner still has `req` asserted, it wins. Otherwise the lock is released this cycle.
- Both ports requesting and no lock: the port other than `last_owner` wins (round-robin, see Configuration).
- Only one port requesting: that port wins.
- Grant is combinational: `gnt` is high in the same cycle as `req` for the winner only.

**Memory drive**
- For the winner with in-range `addr` (`addr < DATA_WORDS`): `mem_en = 1`, `mem_we = we`, `mem_addr = (addr + BASE_ADDR)[MEM_AW-1:0]`, `mem_di = wdata`.
- Out-of-range access: still granted, but `mem_en = 0`, so no RAM access and no wrap into the instruction region.

**Registered state, updated on each grant**
- `last_owner` records the winner.
- `lock_active` is set to the winner's `lock` input.
- Response pipeline (`pend_valid`, `pend_port`, `pend_err`, `pend_we`) records the granted access.

**Response, cycle after the grant**
- In-range read: `rvalid` to `pend_port`, `rdata = mem_dout`.
- Out-of-range read: `rvalid` and `err` to `pend_port`, `rdata = 0`.
- In-range write: no `rvalid`.
- Out-of-range write: `err` pulse only.

**Other rules**
- No requests: all memory outputs are 0; pipeline valid clears next edge.
- Back-to-back grants are allowed. Throughput is one access per cycle; the pipeline is one entry deep and never stalls.
- Read-after-write to the same address in consecutive cycles returns the new data (RAM is write-first).

## Timing
- Reset values (while `reset` is high, regardless of `req`):
  - `gnt*`, `rvalid*`, `err*`, `mem_en`, `mem_we` = 0.
  - `rdata*`, `mem_addr`, `mem_di` = 0.
  - `last_owner` = port 1, so port 0 wins the first tie.
  - `lock_active` = 0; `pend_valid` = 0.
- Grant latency: 0 cycles. Read latency: 1 cycle from the grant edge.
- Reset asserted with a read in flight: the pending response is dropped and no `rvalid` appears after reset release.
- `req` dropped while the port is granted: no access is issued; a requester must hold `req` until it sees `gnt`.
- Lock holder drops `req`: the lock is released that same cycle and the other port may be granted immediately.

## Configuration
- `DMEM_ARB_RR_EN` defined: round-robin tie-break as described above.
- `DMEM_ARB_RR_EN` undefined: fixed priority, port 0 always wins ties. Lock handling is unchanged. `last_owner` is still kept, but not used for selection.

## Structure
- Package `dmem_arb_pkg` holds:
  - constants `PORT_CPU = 1'b0`, `PORT_LDR = 1'b1`;
  - defaults for `BASE_ADDR`, `DATA_WORDS`, `MEM_AW`;
  - typedef `arb_port_t` (1-bit owner id).
- One sub-module, `dmem_arb_pick`: combinational winner selection from `req`, `lock_active`, `lock owner` and `last_owner`, with the macro applied inside it.

## Test plan
1. Reset, then `req0` read `addr0 = 5` (RAM[517] = 0xBEEF) -> `gnt0` same cycle, `mem_addr = 517`; next cycle `rvalid0 = 1`, `rdata0 = 0xBEEF`.
2. `req0` and `req1` both held 4 cycles (RR enabled) -> grants go 0, 1, 0, 1. Same stimulus with the macro off -> 0, 0, 0, 0.
3. `req1` + `lock1` for 3 cycles while `req0` is held -> `gnt1` for 3 cycles. Then `lock1` and `req1` drop -> `gnt0` in the next cycle.
4. `req1` write `addr1 = 600`, `wdata = 0x1234` -> `gnt1`, `mem_en = 0`, `err1` pulses next cycle, RAM[88] unchanged.
5. `req0` write `addr0 = 3`, data 0x00AA, then read `addr0 = 3` next cycle -> `rdata0 = 0x00AA` with `rvalid0`.
6. `req0` read granted, `reset` asserted before the next edge -> no `rvalid0` after release; all outputs 0 during reset.
